// File: rtl/alu_op_sequencer.sv
// Multi-cycle request/response controller around a combinational ALU.
// Operands stay on the ALU for a per-class settle window, then the 64-bit result is held for a response handshake.
module alu_op_sequencer #(
  parameter int BASIC_CYCLES  = 1,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_value1,
  output logic [31:0] alu_value2,
  output logic [4:0]  alu_select,
  input  logic [63:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_zlo,
  output logic [31:0] rsp_zhi,
  output logic        rsp_err,
  output logic        hilo_we,
  output logic        busy
);

  localparam int MAX_CYCLES = (BASIC_CYCLES > MULDIV_CYCLES) ? BASIC_CYCLES : MULDIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [4:0] OP_DIV = 5'd11;
  localparam logic [4:0] OP_MUL = 5'd12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [31:0]        a_q;
  logic [31:0]        b_q;
  logic [4:0]         op_q;
  logic [31:0]        zlo_q;
  logic [31:0]        zhi_q;
  logic               err_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               req_legal;
  logic               req_div0;
  logic               req_muldiv;
  logic               req_reject;
  logic               op_muldiv;
  logic               accept;

  assign req_legal  = (req_op >= 5'd1) && (req_op <= 5'd14);
  assign req_div0   = (req_op == OP_DIV) && (req_b == 32'd0);
  assign req_muldiv = (req_op == OP_DIV) || (req_op == OP_MUL);
  assign req_reject = !req_legal || req_div0;
  assign op_muldiv  = (op_q == OP_DIV) || (op_q == OP_MUL);
  assign accept     = (state == IDLE) && req_valid;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_next = req_reject ? RESP : EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Rejected requests (illegal op, divide by zero) answer immediately with a zero result.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      zlo_q <= '0;
      zhi_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else if (accept) begin
      a_q  <= req_a;
      b_q  <= req_b;
      op_q <= req_op;
      if (req_reject) begin
        zlo_q <= '0;
        zhi_q <= '0;
        err_q <= 1'b1;
      end else begin
        cnt_q <= req_muldiv ? CNT_W'(MULDIV_CYCLES - 1) : CNT_W'(BASIC_CYCLES - 1);
      end
    end else if (state == EXEC) begin
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end else begin
        zlo_q <= alu_result[31:0];
        zhi_q <= op_muldiv ? alu_result[63:32] : 32'd0;
        err_q <= 1'b0;
      end
    end
  end

  always_comb begin
    req_ready  = (state == IDLE);
    busy       = (state != IDLE);
    rsp_valid  = (state == RESP);
    rsp_zlo    = zlo_q;
    rsp_zhi    = zhi_q;
    rsp_err    = err_q;
    hilo_we    = rsp_valid && rsp_ready && op_muldiv && !err_q;
    alu_select = 5'd0;
    alu_value1 = 32'd0;
    alu_value2 = 32'd0;
    if (state == EXEC) begin
      alu_select = op_q;
      alu_value1 = a_q;
      alu_value2 = b_q;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a small behavioural ALU on its ALU port.
// Basic ops put 0xDEADBEEF on the ALU's upper half so a missing ZHI clear shows up.
module tb_alu_op_sequencer;

  logic        clock;
  logic        clear;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [31:0] alu_value1;
  logic [31:0] alu_value2;
  logic [4:0]  alu_select;
  logic [63:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_zlo;
  logic [31:0] rsp_zhi;
  logic        rsp_err;
  logic        hilo_we;
  logic        busy;

  int checks;
  int errors;
  int hilo_pulses;

  alu_op_sequencer #(
    .BASIC_CYCLES  (1),
    .MULDIV_CYCLES (4)
  ) dut (
    .clock      (clock),
    .clear      (clear),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_value1 (alu_value1),
    .alu_value2 (alu_value2),
    .alu_select (alu_select),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_zlo    (rsp_zlo),
    .rsp_zhi    (rsp_zhi),
    .rsp_err    (rsp_err),
    .hilo_we    (hilo_we),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural ALU: div gives {remainder, quotient}, mul is unsigned 32x32.
  always_comb begin
    alu_result = 64'd0;
    case (alu_select)
      5'd1:  alu_result = {32'hDEAD_BEEF, alu_value1 + alu_value2};
      5'd2:  alu_result = {32'hDEAD_BEEF, alu_value1 - alu_value2};
      5'd8:  alu_result = {32'hDEAD_BEEF, alu_value1 << alu_value2[4:0]};
      5'd11: if (alu_value2 != 32'd0) alu_result = {alu_value1 % alu_value2, alu_value1 / alu_value2};
      5'd12: alu_result = {32'd0, alu_value1} * {32'd0, alu_value2};
      default: alu_result = 64'd0;
    endcase
  end

  always @(posedge clock) begin
    if (hilo_we) hilo_pulses <= hilo_pulses + 1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents one request for a single edge; returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  // lat counts edges after the accepting edge until rsp_valid is seen.
  task automatic waitResponse(input logic [4:0] sel, output int lat, output int sel_cnt);
    lat     = 0;
    sel_cnt = 0;
    while (!rsp_valid && lat < 50) begin
      if (alu_select == sel) sel_cnt++;
      @(posedge clock);
      #1;
      lat++;
    end
    if (!rsp_valid) checkOutput("rsp_timeout", 64'(rsp_valid), 64'd1);
  endtask

  int lat;
  int sel_cnt;
  int pulses0;
  logic [4:0] bad_ops [3];

  initial begin
    checks      = 0;
    errors      = 0;
    hilo_pulses = 0;
    clear       = 1'b1;
    req_valid   = 1'b0;
    req_op      = 5'd0;
    req_a       = 32'd0;
    req_b       = 32'd0;
    rsp_ready   = 1'b1;
    bad_ops[0]  = 5'd11;
    bad_ops[1]  = 5'd0;
    bad_ops[2]  = 5'd20;

    #12;
    checkOutput("rst_req_ready", 64'(req_ready), 64'd1);
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_hilo_we", 64'(hilo_we), 64'd0);
    checkOutput("rst_alu", {27'd0, alu_select, alu_value1}, 64'd0);
    checkOutput("rst_zlo_zhi", {rsp_zhi, rsp_zlo}, 64'd0);
    @(posedge clock);
    #1;
    clear = 1'b0;

    // Add
    pulses0 = hilo_pulses;
    applyStimulus(5'd1, 32'h5, 32'h7);
    checkOutput("add_exec_select", 64'(alu_select), 64'd1);
    checkOutput("add_exec_req_ready", 64'(req_ready), 64'd0);
    waitResponse(5'd1, lat, sel_cnt);
    checkOutput("add_latency", 64'(lat), 64'd1);
    checkOutput("add_select_cycles", 64'(sel_cnt), 64'd1);
    checkOutput("add_zlo", 64'(rsp_zlo), 64'hC);
    checkOutput("add_zhi", 64'(rsp_zhi), 64'd0);
    checkOutput("add_err", 64'(rsp_err), 64'd0);
    checkOutput("add_resp_select", 64'(alu_select), 64'd0);
    @(posedge clock);
    #1;
    checkOutput("add_back_idle", 64'(busy), 64'd0);
    checkOutput("add_hilo", 64'(hilo_pulses - pulses0), 64'd0);

    // Mul with a held response so hilo_we can be watched around the handshake
    pulses0   = hilo_pulses;
    rsp_ready = 1'b0;
    applyStimulus(5'd12, 32'hFFFF_FFFF, 32'd2);
    waitResponse(5'd12, lat, sel_cnt);
    checkOutput("mul_latency", 64'(lat), 64'd4);
    checkOutput("mul_select_cycles", 64'(sel_cnt), 64'd4);
    checkOutput("mul_result", {rsp_zhi, rsp_zlo}, 64'h0000_0001_FFFF_FFFE);
    checkOutput("mul_hilo_before", 64'(hilo_we), 64'd0);
    rsp_ready = 1'b1;
    #1;
    checkOutput("mul_hilo_at_hs", 64'(hilo_we), 64'd1);
    @(posedge clock);
    #1;
    checkOutput("mul_hilo_after", 64'(hilo_we), 64'd0);
    checkOutput("mul_hilo_pulses", 64'(hilo_pulses - pulses0), 64'd1);

    // Divide by zero and illegal op codes all take the error path
    foreach (bad_ops[i]) begin
      pulses0 = hilo_pulses;
      applyStimulus(bad_ops[i], 32'd123, 32'd0);
      waitResponse(bad_ops[i], lat, sel_cnt);
      checkOutput($sformatf("err%0d_latency", bad_ops[i]), 64'(lat), 64'd0);
      checkOutput($sformatf("err%0d_no_exec", bad_ops[i]), 64'(busy && !rsp_valid), 64'd0);
      checkOutput($sformatf("err%0d_result", bad_ops[i]), {rsp_zhi, rsp_zlo}, 64'd0);
      checkOutput($sformatf("err%0d_err", bad_ops[i]), 64'(rsp_err), 64'd1);
      checkOutput($sformatf("err%0d_hilo_we", bad_ops[i]), 64'(hilo_we), 64'd0);
      @(posedge clock);
      #1;
      checkOutput($sformatf("err%0d_pulses", bad_ops[i]), 64'(hilo_pulses - pulses0), 64'd0);
    end

    // Backpressure with a competing request held on the inputs
    rsp_ready = 1'b0;
    applyStimulus(5'd2, 32'd10, 32'd3);
    waitResponse(5'd2, lat, sel_cnt);
    req_op    = 5'd1;
    req_a     = 32'd1;
    req_b     = 32'd1;
    req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("bp_hold%0d", c), {29'd0, rsp_valid, req_ready, rsp_err, rsp_zlo}, {29'd0, 1'b1, 1'b0, 1'b0, 32'd7});
      @(posedge clock);
      #1;
    end
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("bp_idle_ready", 64'(req_ready), 64'd1);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    checkOutput("bp_second_exec", 64'(alu_select), 64'd1);
    waitResponse(5'd1, lat, sel_cnt);
    checkOutput("bp_second_zlo", 64'(rsp_zlo), 64'd2);
    @(posedge clock);
    #1;

    // Reset in the second EXEC cycle of a divide
    pulses0 = hilo_pulses;
    applyStimulus(5'd11, 32'd100, 32'd7);
    @(posedge clock);
    #1;
    checkOutput("rmid_in_exec", 64'(alu_select), 64'd11);
    #2;
    clear = 1'b1;
    #1;
    checkOutput("rmid_busy", 64'(busy), 64'd0);
    checkOutput("rmid_req_ready", 64'(req_ready), 64'd1);
    checkOutput("rmid_alu", {27'd0, alu_select, alu_value1}, 64'd0);
    checkOutput("rmid_alu_v2", 64'(alu_value2), 64'd0);
    checkOutput("rmid_outputs", {rsp_zhi, rsp_zlo}, 64'd0);
    @(posedge clock);
    #1;
    clear = 1'b0;
    for (int c = 0; c < 6; c++) begin
      checkOutput($sformatf("rmid_no_rsp%0d", c), 64'(rsp_valid), 64'd0);
      @(posedge clock);
      #1;
    end
    checkOutput("rmid_no_hilo", 64'(hilo_pulses - pulses0), 64'd0);

    // Shift left: upper half must be cleared despite the ALU driving 0xDEADBEEF
    applyStimulus(5'd8, 32'h8000_0001, 32'd1);
    waitResponse(5'd8, lat, sel_cnt);
    checkOutput("shl_zlo", 64'(rsp_zlo), 64'h2);
    checkOutput("shl_zhi", 64'(rsp_zhi), 64'd0);
    @(posedge clock);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
